// File: rtl/elevator_scheduler.sv
// SCAN request scheduler and motion/door sequencer for one elevator car.
// Optional emergency stop (estop port, HALT state) is built when SCHED_ESTOP_EN is defined.
module elevator_scheduler #(
    parameter int FLOORS      = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               int_valid,
    input  logic [FLOOR_W-1:0] int_floor,
    input  logic               ext_valid,
    input  logic [FLOOR_W-1:0] ext_floor,
    input  logic               floor_tick,
`ifdef SCHED_ESTOP_EN
    input  logic               estop,
`endif
    output logic [1:0]         engine,
    output logic [2:0]         doors,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOORS-1:0]  pending,
    output logic               busy
);

    localparam int TMR_W = $clog2(DOOR_CYCLES);
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W:0]   FLOORS_X  = (FLOOR_W + 1)'(FLOORS);

    localparam logic [1:0] ENG_STOP = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b01;
    localparam logic [1:0] ENG_DOWN = 2'b10;
    localparam logic [2:0] DOORS_CLOSED  = 3'b001;
    localparam logic [2:0] DOORS_OPEN    = 3'b010;
    localparam logic [2:0] DOORS_CLOSING = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DOOR,
        S_CLOSE
`ifdef SCHED_ESTOP_EN
        , S_HALT
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
    logic [FLOORS-1:0]    pending_q, pending_d;
    logic                 dir_up_q, dir_up_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [1:0]           engine_q, engine_d;
    logic [2:0]           doors_q, doors_d;
    logic                 busy_q, busy_d;

    logic                 int_ok, ext_ok, door_phase, reopen;
    logic                 any_above, any_below, at_top, at_bottom;
    logic [FLOOR_W-1:0]   up_floor, down_floor;
    logic [FLOORS-1:0]    set_mask, above_mask, below_mask;

    assign int_ok     = enable && int_valid && ({1'b0, int_floor} < FLOORS_X);
    assign ext_ok     = enable && ext_valid && ({1'b0, ext_floor} < FLOORS_X);
    assign door_phase = (state_q == S_DOOR) || (state_q == S_CLOSE);
    // A call for the floor the car is standing at with doors open keeps them open instead of queuing.
    assign reopen     = door_phase &&
                        ((int_ok && int_floor == cur_floor_q) || (ext_ok && ext_floor == cur_floor_q));

    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_floor
        localparam logic [FLOOR_W-1:0] FI = FLOOR_W'(gi);
        assign set_mask[gi]   = ((int_ok && int_floor == FI) || (ext_ok && ext_floor == FI)) &&
                                !(door_phase && cur_floor_q == FI);
        assign above_mask[gi] = pending_q[gi] && (FI > cur_floor_q);
        assign below_mask[gi] = pending_q[gi] && (FI < cur_floor_q);
    end

    assign any_above  = |above_mask;
    assign any_below  = |below_mask;
    assign at_top     = (cur_floor_q == TOP_FLOOR);
    assign at_bottom  = (cur_floor_q == '0);
    assign up_floor   = cur_floor_q + 1'b1;
    assign down_floor = cur_floor_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        pending_d   = pending_q | set_mask;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;

        case (state_q)
            S_IDLE: begin
                if (pending_q[cur_floor_q]) begin
                    state_d                = S_DOOR;
                    pending_d[cur_floor_q] = 1'b0;
                    timer_d                = TMR_LOAD;
                end else if (any_above && (dir_up_q || !any_below)) begin
                    state_d  = S_UP;
                    dir_up_d = 1'b1;
                end else if (any_below) begin
                    state_d  = S_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            S_UP: begin
                if (floor_tick && !at_top) begin
                    cur_floor_d = up_floor;
                    if (pending_q[up_floor]) begin
                        state_d             = S_DOOR;
                        pending_d[up_floor] = 1'b0;
                        timer_d             = TMR_LOAD;
                    end
                end
            end
            S_DOWN: begin
                if (floor_tick && !at_bottom) begin
                    cur_floor_d = down_floor;
                    if (pending_q[down_floor]) begin
                        state_d               = S_DOOR;
                        pending_d[down_floor] = 1'b0;
                        timer_d               = TMR_LOAD;
                    end
                end
            end
            S_DOOR: begin
                if (reopen) begin
                    timer_d = TMR_LOAD;
                end else if (timer_q == '0) begin
                    state_d = S_CLOSE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_CLOSE: begin
                // Keep sweeping the same way while work remains ahead, otherwise turn around.
                if (reopen) begin
                    state_d = S_DOOR;
                    timer_d = TMR_LOAD;
                end else if (dir_up_q ? any_above : any_below) begin
                    state_d = dir_up_q ? S_UP : S_DOWN;
                end else if (dir_up_q ? any_below : any_above) begin
                    state_d  = dir_up_q ? S_DOWN : S_UP;
                    dir_up_d = !dir_up_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef SCHED_ESTOP_EN
            S_HALT: begin
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SCHED_ESTOP_EN
        // Emergency stop freezes position and keeps every outstanding call.
        if (estop) begin
            state_d     = S_HALT;
            cur_floor_d = cur_floor_q;
            pending_d   = pending_q | set_mask;
            dir_up_d    = dir_up_q;
            timer_d     = '0;
        end
`endif
    end

    always_comb begin
        engine_d = ENG_STOP;
        doors_d  = DOORS_CLOSED;
        if (state_d == S_UP)   engine_d = ENG_UP;
        if (state_d == S_DOWN) engine_d = ENG_DOWN;
        if (state_d == S_DOOR)  doors_d = DOORS_OPEN;
        if (state_d == S_CLOSE) doors_d = DOORS_CLOSING;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cur_floor_q <= '0;
            pending_q   <= '0;
            dir_up_q    <= 1'b1;
            timer_q     <= '0;
            engine_q    <= ENG_STOP;
            doors_q     <= DOORS_CLOSED;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
            dir_up_q    <= dir_up_d;
            timer_q     <= timer_d;
            engine_q    <= engine_d;
            doors_q     <= doors_d;
            busy_q      <= busy_d;
        end
    end

    assign engine    = engine_q;
    assign doors     = doors_q;
    assign cur_floor = cur_floor_q;
    assign pending   = pending_q;
    assign busy      = busy_q;

endmodule
